// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader
// Purpose  : Loads a program into the CPU's instruction memory from a framed
//            byte stream, then starts the CPU.
//            The frame is: 0xA5, count N, then 2N data bytes (MSB first per
//            word), then a checksum byte. N=0 means 2^ADDR_W words. The
//            checksum is the 8-bit sum of the data bytes.
//            A good frame gives a one-cycle CPU reset pulse and then sets ON.
//            A bad frame sets a sticky error.
// Ports    : i_clk, i_rst_n             clock, async active-low reset
//            i_byte/i_byte_valid/o_byte_ready   byte stream handshake
//            o_instr_addr/o_instr/o_we  instruction-memory write port
//            o_cpu_on, o_cpu_rst        CPU run enable, CPU reset pulse
//            o_busy, o_err, o_words_loaded      frame status
// Revision : 1.0  initial release
// ============================================================================
module prog_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [7:0]        i_byte,
  input  logic              i_byte_valid,
  output logic              o_byte_ready,
  output logic [ADDR_W-1:0] o_instr_addr,
  output logic [DATA_W-1:0] o_instr,
  output logic              o_we,
  output logic              o_cpu_on,
  output logic              o_cpu_rst,
  output logic              o_busy,
  output logic              o_err,
  output logic [ADDR_W:0]   o_words_loaded
);

  localparam logic [7:0] c_HEADER = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_HI    = 3'd2,
    S_LO    = 3'd3,
    S_CHK   = 3'd4,
    S_BOOT  = 3'd5,
    S_RUN   = 3'd6
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                r_ready_en;
  logic [ADDR_W-1:0]   r_count;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W:0]     r_words;
  logic [7:0]          r_hi;
  logic [7:0]          r_sum;
  logic [DATA_W-1:0]   r_instr;
  logic                r_we;
  logic                r_cpu_on;
  logic                r_cpu_rst;
  logic                r_busy;
  logic                r_err;
  logic [ADDR_W:0]     r_words_loaded;

  logic                w_accept;
  logic                w_is_hdr;
  logic [ADDR_W:0]     w_n_full;
  logic [ADDR_W:0]     w_words_inc;
  logic [7:0]          w_sum_next;

  // Ready is held low while in reset and during the single BOOT cycle.
  assign o_byte_ready = r_ready_en && (r_state != S_BOOT);

  assign w_accept    = i_byte_valid && o_byte_ready;
  assign w_is_hdr    = (i_byte == c_HEADER);
  // A count of zero stands for a full memory of 2^ADDR_W words.
  assign w_n_full    = {(r_count == '0), r_count};
  assign w_words_inc = r_words + 1'b1;
  assign w_sum_next  = r_sum + i_byte;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_is_hdr) w_state_next = S_COUNT;
      S_COUNT: if (w_accept) w_state_next = S_HI;
      S_HI:    if (w_accept) w_state_next = S_LO;
      S_LO:    if (w_accept) w_state_next = (w_words_inc == w_n_full) ? S_CHK : S_HI;
      S_CHK:   if (w_accept) w_state_next = (i_byte == r_sum) ? S_BOOT : S_IDLE;
      S_BOOT:  w_state_next = S_RUN;
      S_RUN:   if (w_accept && w_is_hdr) w_state_next = S_COUNT;
      default: w_state_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ready_en     <= 1'b0;
      r_count        <= '0;
      r_addr         <= '0;
      r_words        <= '0;
      r_hi           <= '0;
      r_sum          <= '0;
      r_instr        <= '0;
      r_we           <= 1'b0;
      r_cpu_on       <= 1'b0;
      r_cpu_rst      <= 1'b0;
      r_busy         <= 1'b0;
      r_err          <= 1'b0;
      r_words_loaded <= '0;
    end else begin
      r_ready_en <= 1'b1;
      r_we       <= 1'b0;
      r_cpu_rst  <= 1'b0;

      // The address advances on the cycle after the write pulse. This keeps
      // o_instr_addr equal to the slot being written while o_we is high.
      if (r_we) begin
        r_addr <= r_addr + 1'b1;
      end

      case (r_state)
        S_IDLE, S_RUN: begin
          if (w_accept && w_is_hdr) begin
            r_err    <= 1'b0;
            r_addr   <= '0;
            r_words  <= '0;
            r_sum    <= '0;
            r_busy   <= 1'b1;
            r_cpu_on <= 1'b0;
          end
        end
        S_COUNT: begin
          if (w_accept) r_count <= ADDR_W'(i_byte);
        end
        S_HI: begin
          if (w_accept) begin
            r_hi  <= i_byte;
            r_sum <= w_sum_next;
          end
        end
        S_LO: begin
          if (w_accept) begin
            r_sum   <= w_sum_next;
            r_instr <= DATA_W'({r_hi, i_byte});
            r_we    <= 1'b1;
            r_words <= w_words_inc;
          end
        end
        S_CHK: begin
          if (w_accept) begin
            r_words_loaded <= w_n_full;
            r_busy         <= 1'b0;
            if (i_byte == r_sum) r_cpu_rst <= 1'b1;
            else                 r_err     <= 1'b1;
          end
        end
        S_BOOT: begin
          r_cpu_on <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_instr_addr   = r_addr;
  assign o_instr        = r_instr;
  assign o_we           = r_we;
  assign o_cpu_on       = r_cpu_on;
  assign o_cpu_rst      = r_cpu_rst;
  assign o_busy         = r_busy;
  assign o_err          = r_err;
  assign o_words_loaded = r_words_loaded;

endmodule
`default_nettype wire

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Byte-stream program loader that drives the CPU's instruction-memory write port (instr_addr / instr / we) and its ON and reset inputs.
- Receives a framed program image over a valid/ready byte interface, for example from a UART receiver.
- Assembles 16-bit instruction words and writes them to consecutive addresses starting at 0.
- Holds the CPU off during the load. On a good checksum it pulses the CPU reset and then sets ON.

Parameters:
- ADDR_W, 8, instruction-memory address width.
- DATA_W, 16, instruction width. Fixed at 2 bytes; other values are unsupported.

Ports:
- i_clk  in  1  system clock, rising-edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_byte  in  8  incoming stream byte.
- i_byte_valid  in  1  i_byte is valid.
- o_byte_ready  out  1  loader can accept a byte.
- o_instr_addr  out  ADDR_W  instruction-memory write address.
- o_instr  out  DATA_W  instruction-memory write data.
- o_we  out  1  instruction-memory write enable, one-cycle pulse per word.
- o_cpu_on  out  1  CPU ON (run enable).
- o_cpu_rst  out  1  CPU reset, active-high, one-cycle pulse.
- o_busy  out  1  a frame is in progress.
- o_err  out  1  last frame failed its checksum; sticky until the next header.
- o_words_loaded  out  ADDR_W+1  words written by the last frame.

Behaviour:
- Byte transfer: a byte is accepted on a rising edge where i_byte_valid && o_byte_ready. Gaps in valid are allowed and do not change state.
- Frame format: header 0xA5, then count N (0 encodes 2^ADDR_W words), then 2N data bytes (MSB first per word), then a checksum byte. The checksum is the 8-bit sum of the data bytes only, with carries discarded.
- States: IDLE, COUNT, HI, LO, CHK, BOOT, RUN.
- IDLE:
  - Non-0xA5 bytes are discarded.
  - 0xA5 -> COUNT: clear o_err, clear the address counter and checksum, set o_busy=1.
- COUNT: latch N, go to HI.
- HI: latch the high byte, add it to the checksum, go to LO.
- LO:
  - Add the low byte to the checksum.
  - On the next cycle, drive o_we=1 for exactly one cycle with o_instr={hi,lo} and o_instr_addr=the current counter.
  - The counter increments after the write. It wraps modulo 2^ADDR_W, so a 256-word load ends at address 0xFF.
  - If words written == N, go to CHK; else go to HI.
  - The write pulse may coincide with acceptance of the next HI byte.
- CHK:
  - Compare the received byte to the checksum.
  - Set o_words_loaded=N (value 2^ADDR_W when N=0) and o_busy=0.
  - Match -> BOOT.
  - Mismatch -> set o_err=1, keep o_cpu_on=0, go to IDLE. Words already written stay in memory.
- BOOT:
  - o_byte_ready=0 for this single cycle.
  - o_cpu_rst=1 for this single cycle.
  - Next cycle: o_cpu_on=1, go to RUN.
- RUN:
  - o_cpu_on stays 1. Non-header bytes are discarded.
  - 0xA5 starts a reload: o_cpu_on=0 from the next cycle, go to COUNT with the same actions as in IDLE.
- o_byte_ready: 1 in every state except BOOT.
- Reset (any time, including mid-frame): state=IDLE, and all outputs are 0. This includes o_cpu_on=0, o_we=0, o_err=0, o_words_loaded=0 and o_byte_ready=0 while in reset.
  - o_byte_ready returns to 1 on the first clock after reset deasserts.
  - Partially loaded memory is not cleared.
- The checksum is computed from the data bytes only. The header and count bytes do not contribute.

Test Plan:
- Basic load: after reset, send A5 02 12 34 AB CD BE.
  - Expect o_we pulses at addr 0x00 with data 0x1234, then addr 0x01 with data 0xABCD.
  - Then o_cpu_rst high for 1 cycle, then o_cpu_on=1, o_words_loaded=2, o_err=0.
- Bad checksum: the same frame with checksum 0xBF.
  - Expect both writes, then o_err=1, o_cpu_on=0, no o_cpu_rst pulse, and return to IDLE.
- Garbage before header: send 00 FF 5A, then a valid one-word frame A5 01 00 07 07.
  - Expect no writes before the header, then a single write of 0x0007 at addr 0x00, then boot.
- Full memory: N=0 with 512 data bytes and valid deasserted every other cycle.
  - Expect 256 writes at addresses 0x00..0xFF, o_words_loaded=256, and boot on a correct checksum.
- Reset mid-frame: assert i_rst_n low after A5 03 11.
  - Expect all outputs 0 and IDLE. A subsequent full frame loads from addr 0x00 correctly.
- Reload while running: after a successful boot, send A5.
  - Expect o_cpu_on=0 the next cycle and o_busy=1. A new frame overwrites from addr 0x00 and re-boots.
